cpu_core_mc: RTL and testbench
==============================

Name: cpu_core_mc

Overview:
- Parametrised multicycle successor to the single-cycle 24-bit core: PC, decoder, register file, ALU and ZF are kept, and instruction and data memory move behind external req/ack ports.
- A fetch/execute/memory state machine tolerates variable-latency memories and adds shifts, a JNZ branch, HALT and a retire strobe.
- Sits directly under the system top, beside the external imem and dmem blocks.

Parameters:
- DATA_W, 24: datapath, register and dmem data width (minimum 8).
- REG_N, 16: register count, range 2..16. Register indices >= REG_N read 0; writes to them are dropped.
- PC_W, 8: PC and imem address width (minimum 8).
- ADDR_W, 8: dmem address width; the address is the low ADDR_W bits of the source register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, equal to the PC.
- imem_ack  in  1  fetch complete; imem_rdata is valid in this cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  data access complete; dmem_rdata is valid in this cycle for loads.
- dmem_rdata  in  DATA_W  load data.
- halted  out  1  high while in HALT.
- retire  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Instruction format: op[15:12] opcode, [11:8] dst, [7:4] src0, [3:0] src1. imm8 = op[7:0].
- Opcodes (R = register file):
  - 0 NOP
  - 1 ADD: R[dst] = R[src0] + R[src1]
  - 2 SUB: R[dst] = R[src0] - R[src1]
  - 3 AND, 4 OR, 5 XOR: R[dst] = R[src0] op R[src1]
  - 6 SHL: R[src0] << R[src1][4:0]
  - 7 SHR: logical right shift by R[src1][4:0]
  - 8 LI: R[dst] = zero-extended imm8
  - 9 LD: R[dst] = mem[R[src1]]
  - A ST: mem[R[src1]] = R[src0]
  - B JMP: pc = imm8
  - C JZ: jump to imm8 if zf = 1
  - D JNZ: jump to imm8 if zf = 0
  - E HALT
  - F: treated as NOP
- Arithmetic is modulo 2^DATA_W. A shift amount >= DATA_W yields 0.
- ZF is set to (result == 0) by opcodes 1-7 only. All other opcodes hold ZF.
- Jump targets are imm8 zero-extended/truncated to PC_W. The sequential PC is pc+1 mod 2^PC_W, so it wraps from all-ones to 0.
- State machine (Moore): all req, halted and retire outputs decode from registered state only.
  - FETCH: imem_req = 1, imem_addr = pc. On the imem_ack cycle, latch IR and go to EXEC. Without ack, stay in FETCH.
  - EXEC (one cycle):
    - ALU, LI, NOP, F: write R[dst] (and ZF if applicable), pc+1, retire, go to FETCH.
    - Jumps: update pc, retire, go to FETCH.
    - LD/ST: latch address and store data, go to MEM.
    - HALT: go to HALT; pc is not advanced.
  - MEM: dmem_req = 1 with dmem_we/addr/wdata stable. On the dmem_ack cycle: LD writes R[dst] = dmem_rdata, pc+1, retire, go to FETCH.
  - HALT: terminal; halted = 1 and no requests are issued. Left only by rst.
- Handshake rules:
  - req rises on entry to its state and stays high with stable address/data until ack is sampled high.
  - Ack in the first req cycle is legal (zero wait).
  - req is low in the cycle after the ack.
  - ack while req is low is ignored.
- Latency with zero-wait memories: ALU, LI and jump instructions take 2 cycles; LD/ST take 3.
- retire is asserted in the completing state (EXEC, or MEM on the dmem_ack cycle) and registered so it pulses the cycle after completion.
- Reset values: pc = 0, all registers 0, zf = 0, state FETCH, IR = 0, retire = 0, halted = 0. imem_req = 1 in the first cycle after rst deasserts.
- Reset mid-transaction: requests drop asynchronously with state, and any in-flight ack is discarded. No partial register or PC update occurs.
- Register reads are combinational. A write in EXEC is visible to the next instruction.

Test Plan:
- Reset, then program LI r1,5; LI r2,5; SUB r3,r1,r2; JZ 0x10, zero-wait imem -> r3 = 0, zf = 1, pc = 0x10 after 8 cycles, 4 retire pulses.
- Program LI r1,0x40; LI r2,0x7; ST r2→[r1]; LD r4←[r1] with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles per access with addr 0x40 stable, store wdata = 7, r4 = 7.
- imem_ack withheld 5 cycles during fetch -> imem_addr stable, no retire, state remains FETCH.
- SHL with R[src1] = 30 (DATA_W = 24) -> result 0, zf = 1. ADD 0xFFFFFF + 1 -> 0, zf = 1.
- PC at 0xFF executing NOP -> next fetch address 0x00. HALT -> halted = 1, no further imem_req until rst.
- rst asserted during a MEM wait with dmem_req high -> dmem_req low immediately, destination register unchanged (0), pc = 0, imem_req = 1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/cpu_core_mc_if.sv
// Instruction and data memory req/ack bus between cpu_core_mc and the external imem/dmem blocks.
interface cpu_core_mc_if #(
   parameter int PC_W   = 8,
   parameter int DATA_W = 24,
   parameter int ADDR_W = 8
);
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [15:0]       imem_rdata;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_ack, imem_rdata, dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/cpu_core_mc.sv
// Multicycle core: FETCH/EXEC/MEM state machine over req/ack instruction and data memories.
//   state   | meaning
//   S_FETCH | imem_req high at pc, waiting for imem_ack to latch IR
//   S_EXEC  | one-cycle decode/execute, register/ZF/PC update
//   S_MEM   | dmem_req high with stable addr/data, waiting for dmem_ack
//   S_HALT  | terminal, no requests until rst
module cpu_core_mc #(
   parameter int DATA_W = 24,
   parameter int REG_N  = 16,
   parameter int PC_W   = 8,
   parameter int ADDR_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   cpu_core_mc_if.master bus,
   output logic          halted,
   output logic          retire
);
   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t            state_q;
   logic [PC_W-1:0]   pc_q;
   logic [15:0]       ir_q;
   logic              zf_q;
   logic              retire_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] regs_q [REG_N];

   logic [3:0]        opc, dst, src0, src1;
   logic              dst_ok;
   logic [DATA_W-1:0] a_val, b_val, alu_d;
   logic [4:0]        shamt;
   logic [PC_W-1:0]   pc_seq_d, pc_jmp_d;
   logic              take_jmp;

   assign opc    = ir_q[15:12];
   assign dst    = ir_q[11:8];
   assign src0   = ir_q[7:4];
   assign src1   = ir_q[3:0];
   assign dst_ok = int'(dst) < REG_N;
   assign shamt  = b_val[4:0];

   // Indices beyond the implemented register count read as zero.
   always_comb begin
      a_val = '0;
      b_val = '0;
      if (int'(src0) < REG_N) a_val = regs_q[src0];
      if (int'(src1) < REG_N) b_val = regs_q[src1];
   end

   always_comb begin
      alu_d = '0;
      case (opc)
         4'h1:    alu_d = a_val + b_val;
         4'h2:    alu_d = a_val - b_val;
         4'h3:    alu_d = a_val & b_val;
         4'h4:    alu_d = a_val | b_val;
         4'h5:    alu_d = a_val ^ b_val;
         4'h6:    alu_d = (int'(shamt) >= DATA_W) ? '0 : (a_val << shamt);
         4'h7:    alu_d = (int'(shamt) >= DATA_W) ? '0 : (a_val >> shamt);
         default: alu_d = '0;
      endcase
   end

   assign pc_seq_d = pc_q + PC_W'(1);
   assign pc_jmp_d = PC_W'(ir_q[7:0]);
   assign take_jmp = (opc == 4'hB) || (opc == 4'hC && zf_q) || (opc == 4'hD && !zf_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         zf_q     <= 1'b0;
         retire_q <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               if (bus.imem_ack) begin
                  ir_q    <= bus.imem_rdata;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               state_q <= S_FETCH;
               case (opc)
                  4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                     if (dst_ok) regs_q[dst] <= alu_d;
                     zf_q     <= (alu_d == '0);
                     pc_q     <= pc_seq_d;
                     retire_q <= 1'b1;
                  end
                  4'h8: begin
                     if (dst_ok) regs_q[dst] <= DATA_W'(ir_q[7:0]);
                     pc_q     <= pc_seq_d;
                     retire_q <= 1'b1;
                  end
                  4'h9, 4'hA: begin
                     addr_q  <= b_val[ADDR_W-1:0];
                     wdata_q <= a_val;
                     we_q    <= (opc == 4'hA);
                     state_q <= S_MEM;
                  end
                  4'hB, 4'hC, 4'hD: begin
                     pc_q     <= take_jmp ? pc_jmp_d : pc_seq_d;
                     retire_q <= 1'b1;
                  end
                  4'hE: state_q <= S_HALT;
                  default: begin
                     pc_q     <= pc_seq_d;
                     retire_q <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (bus.dmem_ack) begin
                  if (!we_q && dst_ok) regs_q[dst] <= bus.dmem_rdata;
                  pc_q     <= pc_seq_d;
                  retire_q <= 1'b1;
                  state_q  <= S_FETCH;
               end
            end
            S_HALT: state_q <= S_HALT;
         endcase
      end
   end

   assign bus.imem_req   = (state_q == S_FETCH);
   assign bus.imem_addr  = pc_q;
   assign bus.dmem_req   = (state_q == S_MEM);
   assign bus.dmem_we    = we_q;
   assign bus.dmem_addr  = addr_q;
   assign bus.dmem_wdata = wdata_q;
   assign halted         = (state_q == S_HALT);
   assign retire         = retire_q;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: variable-latency imem/dmem responders with fetch and store scoreboards.
module tb_cpu_core_mc;
   localparam int DATA_W = 24;
   localparam int PC_W   = 8;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic halted, retire;

   cpu_core_mc_if #(.PC_W(PC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   cpu_core_mc #(.DATA_W(DATA_W), .REG_N(16), .PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .halted (halted),
      .retire (retire)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [15:0]       prog [256];
   logic [DATA_W-1:0] dmem [256];
   logic [7:0]        fetch_q [$];
   logic [31:0]       store_q [$];
   int imem_wait = 0;
   int dmem_wait = 0;
   int ret_cnt   = 0;
   int cyc_cnt   = 0;
   int dreq_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial forever begin
      @(posedge clk);
      if (!rst) cyc_cnt++;
   end

   initial forever begin
      @(negedge clk);
      if (retire === 1'b1) ret_cnt++;
      if (bus.dmem_req === 1'b1) dreq_cnt++;
   end

   // instruction memory responder
   initial begin
      int icnt;
      logic [7:0] a0;
      logic acked;
      icnt = 0; a0 = '0; acked = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.imem_ack = 1'b0; icnt = 0; acked = 1'b0;
         end else begin
            if (acked) chk("imem_req_drop", 32'(bus.imem_req), 32'(0));
            acked = 1'b0;
            if (bus.imem_req) begin
               if (icnt == 0) a0 = bus.imem_addr;
               else chk("imem_addr_stable", 32'(bus.imem_addr), 32'(a0));
               if (icnt >= imem_wait) begin
                  bus.imem_ack = 1'b1;
                  bus.imem_rdata = prog[bus.imem_addr];
                  chk("fetch_expected", 32'(fetch_q.size() > 0), 32'(1));
                  if (fetch_q.size() > 0) chk("fetch_addr", 32'(bus.imem_addr), 32'(fetch_q.pop_front()));
                  icnt = 0; acked = 1'b1;
               end else begin
                  bus.imem_ack = 1'b0; icnt++;
               end
            end else begin
               bus.imem_ack = 1'b0; icnt = 0;
            end
         end
      end
   end

   // data memory responder
   initial begin
      int dcnt;
      logic [7:0] a0;
      logic [DATA_W-1:0] w0;
      logic we0, acked;
      dcnt = 0; a0 = '0; w0 = '0; we0 = 1'b0; acked = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = 24'hA5A5A5;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.dmem_ack = 1'b0; dcnt = 0; acked = 1'b0;
         end else begin
            if (acked) chk("dmem_req_drop", 32'(bus.dmem_req), 32'(0));
            acked = 1'b0;
            bus.dmem_rdata = 24'hA5A5A5;
            if (bus.dmem_req) begin
               if (dcnt == 0) begin
                  a0 = bus.dmem_addr; w0 = bus.dmem_wdata; we0 = bus.dmem_we;
               end else begin
                  chk("dmem_addr_stable", 32'(bus.dmem_addr), 32'(a0));
                  chk("dmem_we_stable", 32'(bus.dmem_we), 32'(we0));
                  if (we0) chk("dmem_wdata_stable", 32'(bus.dmem_wdata), 32'(w0));
               end
               if (dcnt >= dmem_wait) begin
                  bus.dmem_ack = 1'b1;
                  if (bus.dmem_we) begin
                     dmem[bus.dmem_addr] = bus.dmem_wdata;
                     chk("store_expected", 32'(store_q.size() > 0), 32'(1));
                     if (store_q.size() > 0) chk("store", {bus.dmem_addr, bus.dmem_wdata}, store_q.pop_front());
                  end else begin
                     bus.dmem_rdata = dmem[bus.dmem_addr];
                  end
                  dcnt = 0; acked = 1'b1;
               end else begin
                  bus.dmem_ack = 1'b0; dcnt++;
               end
            end else begin
               bus.dmem_ack = 1'b0; dcnt = 0;
            end
         end
      end
   end

   task automatic begin_test(input int iw, input int dw);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_clears_halted", 32'(halted), 32'(0));
      for (int i = 0; i < 256; i++) begin
         prog[i] = 16'h0000;
         dmem[i] = '0;
      end
      fetch_q.delete();
      store_q.delete();
      imem_wait = iw;
      dmem_wait = dw;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      cyc_cnt = 0; ret_cnt = 0; dreq_cnt = 0;
      rst = 1'b0;
   endtask

   task automatic expect_fetch(input logic [7:0] a);
      fetch_q.push_back(a);
   endtask

   task automatic expect_store(input logic [7:0] a, input logic [DATA_W-1:0] d);
      store_q.push_back({a, d});
   endtask

   task automatic finish_prog(input string name, input int exp_cyc, input int exp_ret);
      int guard;
      int nreq;
      guard = 0;
      while (halted !== 1'b1 && guard < 400) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk({name, "_halted"}, 32'(halted), 32'(1));
      chk({name, "_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
      chk({name, "_retires"}, 32'(ret_cnt), 32'(exp_ret));
      chk({name, "_fetch_q_left"}, 32'(fetch_q.size()), 32'(0));
      chk({name, "_store_q_left"}, 32'(store_q.size()), 32'(0));
      nreq = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.imem_req === 1'b1 || bus.dmem_req === 1'b1) nreq++;
      end
      chk({name, "_req_after_halt"}, 32'(nreq), 32'(0));
      chk({name, "_halt_held"}, 32'(halted), 32'(1));
   endtask

   initial begin
      int guard;

      // LI/LI/SUB/JZ zero-wait, reset-state checks
      begin_test(0, 0);
      prog[8'h00] = 16'h8105;
      prog[8'h01] = 16'h8205;
      prog[8'h02] = 16'h2312;
      prog[8'h03] = 16'hC010;
      prog[8'h10] = 16'hA031;
      prog[8'h11] = 16'hE000;
      foreach (prog[i]) if (i <= 3) expect_fetch(8'(i));
      expect_fetch(8'h10); expect_fetch(8'h11);
      expect_store(8'h05, 24'h000000);
      release_rst();
      chk("rst_imem_req", 32'(bus.imem_req), 32'(1));
      chk("rst_imem_addr", 32'(bus.imem_addr), 32'(0));
      chk("rst_dmem_req", 32'(bus.dmem_req), 32'(0));
      chk("rst_halted", 32'(halted), 32'(0));
      chk("rst_retire", 32'(retire), 32'(0));
      repeat (8) @(posedge clk);
      @(negedge clk);
      #1;
      chk("t1_pc_after_8", 32'(bus.imem_addr), 32'(8'h10));
      chk("t1_retires_after_8", 32'(ret_cnt), 32'(4));
      finish_prog("t1", 13, 5);

      // ST/LD with dmem_ack delayed 3 cycles
      begin_test(0, 3);
      prog[0] = 16'h8140;
      prog[1] = 16'h8207;
      prog[2] = 16'hA021;
      prog[3] = 16'h9401;
      prog[4] = 16'hA042;
      prog[5] = 16'hE000;
      for (int i = 0; i <= 5; i++) expect_fetch(8'(i));
      expect_store(8'h40, 24'h7);
      expect_store(8'h07, 24'h7);
      release_rst();
      finish_prog("t2", 24, 5);
      chk("t2_dmem_req_cycles", 32'(dreq_cnt), 32'(12));

      // zero-wait LD/ST latency
      begin_test(0, 0);
      prog[0] = 16'h8140;
      prog[1] = 16'hA011;
      prog[2] = 16'h9201;
      prog[3] = 16'hA020;
      prog[4] = 16'hE000;
      for (int i = 0; i <= 4; i++) expect_fetch(8'(i));
      expect_store(8'h40, 24'h40);
      expect_store(8'h00, 24'h40);
      release_rst();
      finish_prog("t2b", 13, 4);
      chk("t2b_dmem_req_cycles", 32'(dreq_cnt), 32'(3));

      // imem_ack withheld 5 cycles
      begin_test(5, 0);
      prog[0] = 16'h8103;
      prog[1] = 16'hA011;
      prog[2] = 16'hE000;
      for (int i = 0; i <= 2; i++) expect_fetch(8'(i));
      expect_store(8'h03, 24'h3);
      release_rst();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("t3_wait_imem_req", 32'(bus.imem_req), 32'(1));
         chk("t3_wait_imem_addr", 32'(bus.imem_addr), 32'(0));
         chk("t3_wait_retire", 32'(retire), 32'(0));
      end
      finish_prog("t3", 22, 2);

      // shifts, wrap-around ADD, JZ/JNZ both ways
      begin_test(0, 0);
      prog[0]  = 16'h811E; prog[1]  = 16'h8201; prog[2]  = 16'h6321; prog[3]  = 16'hD020;
      prog[4]  = 16'hA032; prog[5]  = 16'h84FF; prog[6]  = 16'h8608; prog[7]  = 16'h6546;
      prog[8]  = 16'h4554; prog[9]  = 16'h6556; prog[10] = 16'h4554; prog[11] = 16'hA054;
      prog[12] = 16'h1752; prog[13] = 16'hC030;
      prog[8'h30] = 16'hA072; prog[8'h31] = 16'h7856; prog[8'h32] = 16'hD040;
      prog[8'h40] = 16'hA086; prog[8'h41] = 16'hE000;
      for (int i = 0; i <= 13; i++) expect_fetch(8'(i));
      expect_fetch(8'h30); expect_fetch(8'h31); expect_fetch(8'h32);
      expect_fetch(8'h40); expect_fetch(8'h41);
      expect_store(8'h01, 24'h000000);
      expect_store(8'hFF, 24'hFFFFFF);
      expect_store(8'h01, 24'h000000);
      expect_store(8'h08, 24'h00FFFF);
      release_rst();
      finish_prog("t4", 42, 18);

      // PC wrap 0xFF -> 0x00, opcode F holds ZF
      begin_test(0, 0);
      prog[8'h00] = 16'hC005;
      prog[8'h01] = 16'hB0FD;
      prog[8'hFD] = 16'h2100;
      prog[8'hFE] = 16'hF123;
      prog[8'hFF] = 16'h0000;
      prog[8'h05] = 16'hE000;
      expect_fetch(8'h00); expect_fetch(8'h01); expect_fetch(8'hFD); expect_fetch(8'hFE);
      expect_fetch(8'hFF); expect_fetch(8'h00); expect_fetch(8'h05);
      release_rst();
      finish_prog("t5", 14, 6);

      // reset during a MEM wait
      begin_test(0, 20);
      prog[0] = 16'h8140;
      prog[1] = 16'h9401;
      dmem[8'h40] = 24'h000123;
      expect_fetch(8'h00); expect_fetch(8'h01);
      release_rst();
      guard = 0;
      while (bus.dmem_req !== 1'b1 && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      chk("t6_mem_reached", 32'(bus.dmem_req), 32'(1));
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_drops_dmem_req", 32'(bus.dmem_req), 32'(0));
      chk("t6_rst_retire", 32'(retire), 32'(0));
      chk("t6_fetch_q_used", 32'(fetch_q.size()), 32'(0));
      repeat (2) @(negedge clk);
      prog[0] = 16'hA040;
      prog[1] = 16'hE000;
      dmem_wait = 0;
      expect_fetch(8'h00); expect_fetch(8'h01);
      expect_store(8'h00, 24'h000000);
      release_rst();
      chk("t6_imem_req_after_rst", 32'(bus.imem_req), 32'(1));
      chk("t6_pc_after_rst", 32'(bus.imem_addr), 32'(0));
      finish_prog("t6", 5, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
